mem_bus_ctrl: RTL

// - External-bus controller between the CPU core and external memory.
// - Arbitrates two requesters onto one single-ported memory handshake:
//   - instruction fetch (IF, driven in the CU fetch stage);
//   - data load/store (DAT, driven in execute microsteps).
// - Sequences each access as req/ack with timeout detection.
// - Returns per-requester done pulses; the CU uses them to hold its CAR.

---
 rtl/cpu_bus_pkg.sv | 20 ++
 rtl/rr_arb2.sv | 34 +++
 rtl/mem_bus_ctrl.sv | 116 +++++++++++
 3 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU external-bus controller: FSM state encoding,
// requester IDs and default bus widths.
package cpu_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2,
        ERR    = 2'd3
    } state_t;

    typedef enum logic {
        REQ_IF  = 1'b0,
        REQ_DAT = 1'b1
    } req_id_t;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 16;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter: combinational grant, registered last grant
// that only advances when the FSM accepts a grant.
module rr_arb2
    import cpu_bus_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    req_if,
    input  logic    req_dat,
    input  logic    en,
    output logic    gnt_valid,
    output req_id_t gnt_id,
    output req_id_t last_gnt
);

    assign gnt_valid = req_if | req_dat;

    // On a conflict the requester that did not win last time gets the bus.
    always_comb begin
        gnt_id = REQ_IF;
        if (req_dat && (!req_if || last_gnt == REQ_IF)) begin
            gnt_id = REQ_DAT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt <= REQ_IF;
        end else if (en) begin
            last_gnt <= gnt_id;
        end
    end

endmodule

// File: rtl/mem_bus_ctrl.sv
// External-bus controller: arbitrates fetch and data requesters onto one
// req/ack memory port, with a timeout that raises a sticky bus error.
module mem_bus_ctrl
    import cpu_bus_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 15
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_halt,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic              o_if_done,
    input  logic              i_dat_req,
    input  logic              i_dat_we,
    input  logic [ADDR_W-1:0] i_dat_addr,
    input  logic [DATA_W-1:0] i_dat_wdata,
    output logic              o_dat_done,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_busy,
    output logic              o_err,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic              i_mem_ack,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic [1:0]        o_state
);

    state_t     state;
    req_id_t    gnt_q;
    req_id_t    gnt_id;
    req_id_t    last_gnt;
    logic       gnt_valid;
    logic       grant_en;
    logic [7:0] cnt;

    assign grant_en = (state == IDLE) && !i_halt && gnt_valid;
    assign o_busy   = (state != IDLE);
    assign o_state  = state;

    rr_arb2 u_arb (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .req_if    (i_if_req),
        .req_dat   (i_dat_req),
        .en        (grant_en),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .last_gnt  (last_gnt)
    );

    // The o_mem_* registers double as the latched request; they are zero
    // whenever no access is in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            gnt_q       <= REQ_IF;
            cnt         <= '0;
            o_if_done   <= 1'b0;
            o_dat_done  <= 1'b0;
            o_rdata     <= '0;
            o_err       <= 1'b0;
            o_mem_req   <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
        end else begin
            o_if_done  <= 1'b0;
            o_dat_done <= 1'b0;
            o_rdata    <= '0;
            case (state)
                IDLE: begin
                    if (grant_en) begin
                        state     <= ACCESS;
                        gnt_q     <= gnt_id;
                        cnt       <= '0;
                        o_mem_req <= 1'b1;
                        if (gnt_id == REQ_DAT) begin
                            o_mem_we    <= i_dat_we;
                            o_mem_addr  <= i_dat_addr;
                            o_mem_wdata <= i_dat_wdata;
                        end else begin
                            o_mem_we    <= 1'b0;
                            o_mem_addr  <= i_if_addr;
                            o_mem_wdata <= '0;
                        end
                    end
                end
                ACCESS: begin
                    // Ack is tested first so it wins over a same-cycle timeout.
                    if (i_mem_ack || cnt == 8'(TIMEOUT - 1)) begin
                        state       <= i_mem_ack ? DONE : ERR;
                        o_rdata     <= i_mem_ack ? i_mem_rdata : '0;
                        o_err       <= o_err | !i_mem_ack;
                        o_if_done   <= (gnt_q == REQ_IF);
                        o_dat_done  <= (gnt_q == REQ_DAT);
                        o_mem_req   <= 1'b0;
                        o_mem_we    <= 1'b0;
                        o_mem_addr  <= '0;
                        o_mem_wdata <= '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
